sn194_seq_ctrl: RTL

Command-driven sequencer that sits directly upstream of the SN74LS194 universal shift register emulation. It drives that register's mode pins, serial inputs and parallel inputs. It accepts one command at a time (operation, 4-bit data, step count) over a valid/ready handshake. It then drives the register for exactly COUNT clock steps and signals completion. Its outputs connect pin-for-pin to S1, S0, SR, SL, A, B, C and D of the register, and both blocks share CLK and CLR.

---
 rtl/sn194_seq_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sn194_seq_ctrl.sv
// Command sequencer driving the mode, serial and parallel pins of an SN74LS194 register.
// Optional result capture from the register outputs is enabled with macro SN194_CAPTURE_EN.
module sn194_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [3:0]       CMD_DATA,
  input  logic [CNT_W-1:0] CMD_COUNT,
  input  logic             ABORT,
  output logic             S1,
  output logic             S0,
  output logic             SR,
  output logic             SL,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORTED
`ifdef SN194_CAPTURE_EN
  ,
  input  logic             QA,
  input  logic             QB,
  input  logic             QC,
  input  logic             QD,
  output logic [3:0]       RESULT,
  output logic             RESULT_VALID
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r, state_s;
  logic [1:0]       op_r, op_s;
  logic [3:0]       data_r, data_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       k_r, k_s;
  logic [7:0]       pins_r, pins_s;
  logic             ready_r, ready_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             aborted_r, aborted_s;

  // Pin pattern {S1,S0,SR,SL,A,B,C,D} for step k; shifts feed DATA so that QA..QD ends as DATA[3:0].
  function automatic logic [7:0] step_pins(input logic [1:0] op, input logic [3:0] data,
                                           input logic [1:0] k);
    logic [7:0] p;
    logic [1:0] idx;
    p = {op, 6'b000000};
    idx = 2'd3 - k;
    case (op)
      2'b01:   p[5] = data[k];
      2'b10:   p[4] = data[idx];
      2'b11:   p[3:0] = data;
      default: p[5:0] = 6'b000000;
    endcase
    return p;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    data_s    = data_r;
    cnt_s     = cnt_r;
    k_s       = k_r;
    pins_s    = 8'h00;
    ready_s   = 1'b1;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    aborted_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (CMD_VALID && ready_r) begin
          if (CMD_COUNT == CNT_ZERO) begin
            done_s = 1'b1;
          end else begin
            state_s = RUN;
            op_s    = CMD_OP;
            data_s  = CMD_DATA;
            cnt_s   = CMD_COUNT;
            k_s     = 2'd0;
            pins_s  = step_pins(CMD_OP, CMD_DATA, 2'd0);
            ready_s = 1'b0;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // The current step is already on the pins, so abort still lets it complete.
        if (ABORT || (cnt_r == CNT_ONE)) begin
          state_s   = IDLE;
          cnt_s     = CNT_ZERO;
          done_s    = 1'b1;
          aborted_s = ABORT;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
          k_s     = k_r + 2'd1;
          pins_s  = step_pins(op_r, data_r, k_s);
          ready_s = 1'b0;
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r   <= IDLE;
      op_r      <= 2'b00;
      data_r    <= 4'h0;
      cnt_r     <= CNT_ZERO;
      k_r       <= 2'd0;
      pins_r    <= 8'h00;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      op_r      <= op_s;
      data_r    <= data_s;
      cnt_r     <= cnt_s;
      k_r       <= k_s;
      pins_r    <= pins_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      aborted_r <= aborted_s;
    end
  end

  assign {S1, S0, SR, SL, A, B, C, D} = pins_r;
  assign CMD_READY = ready_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign ABORTED   = aborted_r;

`ifdef SN194_CAPTURE_EN
  logic [3:0] result_r;
  logic       result_valid_r;

  // Mode is hold during the DONE cycle, so the register already shows its final state.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      result_r       <= 4'h0;
      result_valid_r <= 1'b0;
    end else begin
      result_valid_r <= done_r;
      if (done_r) begin
        result_r <= {QA, QB, QC, QD};
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign RESULT       = result_r;
  assign RESULT_VALID = result_valid_r;
`endif

endmodule
